// File: rtl/pixel_bank_scheduler.sv
// Double-buffer controller: producer writes the back bank, the panel scans the front bank,
// and banks swap only on a panel frame boundary. Optional back-bank clear under PIXEL_BANK_CLEAR_EN.
module pixel_bank_scheduler #(
  parameter int unsigned       ADDR_W      = 12,
  parameter int unsigned       DATA_W      = 16,
  parameter logic [DATA_W-1:0] CLEAR_VALUE = '0
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_wr_valid,
  output logic              o_wr_ready,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [DATA_W-1:0] i_wr_data,
  input  logic              i_swap_req,
  output logic              o_swap_busy,
  output logic              o_swap_done,
  input  logic              i_frame_end,
  input  logic [ADDR_W-1:0] i_rd_addr,
  output logic [ADDR_W:0]   o_ram_r_addr,
  output logic [ADDR_W:0]   o_ram_w_addr,
  output logic [DATA_W-1:0] o_ram_w_data,
  output logic              o_ram_w_en,
  output logic              o_front_bank
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_PENDING = 2'd1
`ifdef PIXEL_BANK_CLEAR_EN
    ,S_CLEAR  = 2'd2
`endif
  } state_t;

  state_t              r_state;
  logic                r_front_bank;
  logic                r_swap_done;
  logic                r_ram_w_en;
  logic [ADDR_W:0]     r_ram_w_addr;
  logic [DATA_W-1:0]   r_ram_w_data;

`ifdef PIXEL_BANK_CLEAR_EN
  logic [ADDR_W-1:0]   r_clr_cnt;
  // Set once the last clear word is issued; holds CLEAR one extra cycle so it drains.
  logic                r_clr_wrap;
`else
  logic                w_unused_clear;
  assign w_unused_clear = ^CLEAR_VALUE;
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= S_IDLE;
      r_front_bank <= 1'b0;
      r_swap_done  <= 1'b0;
      r_ram_w_en   <= 1'b0;
      r_ram_w_addr <= '0;
      r_ram_w_data <= '0;
`ifdef PIXEL_BANK_CLEAR_EN
      r_clr_cnt    <= '0;
      r_clr_wrap   <= 1'b0;
`endif
    end else begin
      r_ram_w_en  <= 1'b0;
      r_swap_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_wr_valid) begin
            r_ram_w_en   <= 1'b1;
            r_ram_w_addr <= {~r_front_bank, i_wr_addr};
            r_ram_w_data <= i_wr_data;
          end
          if (i_swap_req) begin
            r_state <= S_PENDING;
          end
        end
        S_PENDING: begin
          if (i_frame_end) begin
            r_front_bank <= ~r_front_bank;
            r_swap_done  <= 1'b1;
`ifdef PIXEL_BANK_CLEAR_EN
            r_state      <= S_CLEAR;
`else
            r_state      <= S_IDLE;
`endif
          end
        end
`ifdef PIXEL_BANK_CLEAR_EN
        // Bank has already toggled, so ~r_front_bank is the new back bank.
        S_CLEAR: begin
          if (!r_clr_wrap) begin
            r_ram_w_en   <= 1'b1;
            r_ram_w_addr <= {~r_front_bank, r_clr_cnt};
            r_ram_w_data <= CLEAR_VALUE;
            r_clr_cnt    <= r_clr_cnt + ADDR_W'(1);
            if (&r_clr_cnt) begin
              r_clr_wrap <= 1'b1;
            end
          end else begin
            r_clr_wrap <= 1'b0;
            r_state    <= S_IDLE;
          end
        end
`endif
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_wr_ready   = (r_state == S_IDLE);
  assign o_swap_busy  = (r_state != S_IDLE);
  assign o_swap_done  = r_swap_done;
  assign o_front_bank = r_front_bank;
  assign o_ram_w_en   = r_ram_w_en;
  assign o_ram_w_addr = r_ram_w_addr;
  assign o_ram_w_data = r_ram_w_data;
  assign o_ram_r_addr = {r_front_bank, i_rd_addr};

endmodule

// File: tb/tb_pixel_bank_scheduler.sv
// Directed bench for pixel_bank_scheduler; the clear tests compile in with PIXEL_BANK_CLEAR_EN.
module tb_pixel_bank_scheduler;
  localparam int unsigned AW = 12;
  localparam int unsigned DW = 16;
  localparam logic [DW-1:0] CLR = 16'hA5A5;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          wr_valid, wr_ready;
  logic [AW-1:0] wr_addr, rd_addr;
  logic [DW-1:0] wr_data;
  logic          swap_req, swap_busy, swap_done, frame_end;
  logic [AW:0]   ram_r_addr, ram_w_addr;
  logic [DW-1:0] ram_w_data;
  logic          ram_w_en, front_bank;

  int n_checks = 0;
  int n_fail   = 0;

  pixel_bank_scheduler #(.ADDR_W(AW), .DATA_W(DW), .CLEAR_VALUE(CLR)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_wr_valid(wr_valid), .o_wr_ready(wr_ready), .i_wr_addr(wr_addr), .i_wr_data(wr_data),
    .i_swap_req(swap_req), .o_swap_busy(swap_busy), .o_swap_done(swap_done),
    .i_frame_end(frame_end), .i_rd_addr(rd_addr),
    .o_ram_r_addr(ram_r_addr), .o_ram_w_addr(ram_w_addr), .o_ram_w_data(ram_w_data),
    .o_ram_w_en(ram_w_en), .o_front_bank(front_bank)
  );

  always #5 clk = ~clk;

  // Advance one clock; outputs are then sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(input string name);
    int k;
    k = 0;
    while (!wr_ready && k < 5000) begin
      tick();
      k++;
    end
    n_checks++;
    if (wr_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL %s: ready=%b after %0d cycles, required 1", name, wr_ready, k);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; wr_valid = 1'b0; wr_addr = '0; wr_data = '0;
    swap_req = 1'b0; frame_end = 1'b0; rd_addr = '0;
    tick(); tick();
    n_checks++;
    if ({wr_ready, swap_busy, swap_done, ram_w_en, front_bank} !== 5'b10000 ||
        ram_w_addr !== 13'h0 || ram_w_data !== 16'h0) begin
      n_fail++;
      $display("FAIL reset_flags: rdy/busy/done/wen/front=%b%b%b%b%b waddr=%h wdata=%h, required 10000 0000 0000",
               wr_ready, swap_busy, swap_done, ram_w_en, front_bank, ram_w_addr, ram_w_data);
    end
    rst_n = 1'b1;
    tick();
    n_checks++;
    if ({wr_ready, swap_busy, ram_w_en, front_bank} !== 4'b1000) begin
      n_fail++;
      $display("FAIL reset_release: rdy/busy/wen/front=%b%b%b%b, required 1000",
               wr_ready, swap_busy, ram_w_en, front_bank);
    end
  endtask

  task automatic test_write();
    wr_valid = 1'b1; wr_addr = 12'h005; wr_data = 16'hC000; rd_addr = 12'h123;
    #1;
    n_checks++;
    if (ram_r_addr !== 13'h0123) begin
      n_fail++; $display("FAIL rd_addr_front0: got %h, required 0123", ram_r_addr);
    end
    tick();
    wr_valid = 1'b0;
    n_checks++;
    if (ram_w_en !== 1'b1 || ram_w_addr !== 13'h1005 || ram_w_data !== 16'hC000) begin
      n_fail++;
      $display("FAIL write_back1: wen=%b addr=%h data=%h, required 1 1005 c000", ram_w_en, ram_w_addr, ram_w_data);
    end
    tick();
    n_checks++;
    if (ram_w_en !== 1'b0) begin
      n_fail++; $display("FAIL write_strobe_len: wen=%b, required 0", ram_w_en);
    end
  endtask

  task automatic test_swap();
    int bad;
    swap_req = 1'b1;
    tick();
    swap_req = 1'b0;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      if (wr_ready !== 1'b0 || swap_busy !== 1'b1 || front_bank !== 1'b0 || swap_done !== 1'b0) bad++;
      if (i < 19) tick();
    end
    n_checks++;
    if (bad != 0) begin
      n_fail++; $display("FAIL pending_hold: %0d bad cycles, required 0", bad);
    end
    frame_end = 1'b1;
    tick();
    frame_end = 1'b0;
    n_checks++;
    if (front_bank !== 1'b1 || swap_done !== 1'b1) begin
      n_fail++; $display("FAIL swap_toggle: front=%b done=%b, required 1 1", front_bank, swap_done);
    end
    tick();
    n_checks++;
    if (swap_done !== 1'b0 || front_bank !== 1'b1) begin
      n_fail++; $display("FAIL swap_done_pulse: done=%b front=%b, required 0 1", swap_done, front_bank);
    end
    wait_ready("swap_settle");
    wr_valid = 1'b1; wr_addr = 12'h005; wr_data = 16'h1234;
    tick();
    wr_valid = 1'b0;
    n_checks++;
    if (ram_w_en !== 1'b1 || ram_w_addr !== 13'h0005 || ram_w_data !== 16'h1234) begin
      n_fail++;
      $display("FAIL write_back0: wen=%b addr=%h data=%h, required 1 0005 1234", ram_w_en, ram_w_addr, ram_w_data);
    end
    n_checks++;
    if (ram_r_addr !== 13'h1123) begin
      n_fail++; $display("FAIL rd_addr_front1: got %h, required 1123", ram_r_addr);
    end
  endtask

  // Front is 1 here: write+swap goes to back bank 0, then swap back to front 0.
  task automatic test_same_cycle();
    wr_valid = 1'b1; wr_addr = 12'h010; wr_data = 16'hBEEF; swap_req = 1'b1;
    tick();
    wr_valid = 1'b0; swap_req = 1'b0;
    n_checks++;
    if (ram_w_en !== 1'b1 || ram_w_addr !== 13'h0010 || ram_w_data !== 16'hBEEF || wr_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL write_plus_swap: wen=%b addr=%h data=%h rdy=%b, required 1 0010 beef 0",
               ram_w_en, ram_w_addr, ram_w_data, wr_ready);
    end
    frame_end = 1'b1;
    tick();
    frame_end = 1'b0;
    n_checks++;
    if (front_bank !== 1'b0 || swap_done !== 1'b1) begin
      n_fail++; $display("FAIL swap_to0: front=%b done=%b, required 0 1", front_bank, swap_done);
    end
    wait_ready("swap_to0_settle");
    swap_req = 1'b1; frame_end = 1'b1;
    tick();
    swap_req = 1'b0; frame_end = 1'b0;
    tick(); tick();
    n_checks++;
    if (front_bank !== 1'b0 || swap_busy !== 1'b1 || swap_done !== 1'b0) begin
      n_fail++;
      $display("FAIL req_with_frame_end: front=%b busy=%b done=%b, required 0 1 0", front_bank, swap_busy, swap_done);
    end
    frame_end = 1'b1;
    tick();
    frame_end = 1'b0;
    n_checks++;
    if (front_bank !== 1'b1 || swap_done !== 1'b1) begin
      n_fail++; $display("FAIL late_swap: front=%b done=%b, required 1 1", front_bank, swap_done);
    end
    wait_ready("late_swap_settle");
    frame_end = 1'b1;
    tick();
    frame_end = 1'b0;
    n_checks++;
    if (front_bank !== 1'b1 || swap_done !== 1'b0 || wr_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL idle_frame_end: front=%b done=%b rdy=%b, required 1 0 1", front_bank, swap_done, wr_ready);
    end
  endtask

`ifdef PIXEL_BANK_CLEAR_EN
  // Front 1 -> 0, so the clear fills bank 1 (0x1000..0x1FFF).
  task automatic test_clear();
    swap_req = 1'b1;
    tick();
    swap_req = 1'b0;
    frame_end = 1'b1;
    tick();
    frame_end = 1'b0;
    n_checks++;
    if (front_bank !== 1'b0 || swap_done !== 1'b1 || ram_w_en !== 1'b0 || wr_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL clear_entry: front=%b done=%b wen=%b rdy=%b, required 0 1 0 0",
               front_bank, swap_done, ram_w_en, wr_ready);
    end
    for (int i = 0; i < 4096; i++) begin
      tick();
      swap_req = (i == 100);
      n_checks++;
      if (ram_w_en !== 1'b1 || ram_w_addr !== {1'b1, AW'(i)} || ram_w_data !== CLR || wr_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL clear_word_%0d: wen=%b addr=%h data=%h rdy=%b, required 1 %h %h 0",
                 i, ram_w_en, ram_w_addr, ram_w_data, wr_ready, {1'b1, AW'(i)}, CLR);
      end
    end
    swap_req = 1'b0;
    tick();
    n_checks++;
    if (wr_ready !== 1'b1 || swap_busy !== 1'b0 || ram_w_en !== 1'b0 || front_bank !== 1'b0) begin
      n_fail++;
      $display("FAIL clear_exit: rdy=%b busy=%b wen=%b front=%b, required 1 0 0 0",
               wr_ready, swap_busy, ram_w_en, front_bank);
    end
  endtask

  task automatic test_reset_mid();
    int k, writes;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    swap_req = 1'b1;
    tick();
    swap_req = 1'b0;
    frame_end = 1'b1;
    tick();
    frame_end = 1'b0;
    k = 0;
    while (!(ram_w_en === 1'b1 && ram_w_addr === 13'h0200) && k < 1000) begin
      tick();
      k++;
    end
    n_checks++;
    if (ram_w_en !== 1'b1 || ram_w_addr !== 13'h0200) begin
      n_fail++; $display("FAIL reach_0x200: wen=%b addr=%h, required 1 0200", ram_w_en, ram_w_addr);
    end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({wr_ready, swap_busy, swap_done, ram_w_en, front_bank} !== 5'b10000 ||
        ram_w_addr !== 13'h0 || ram_w_data !== 16'h0) begin
      n_fail++;
      $display("FAIL reset_mid_clear: rdy/busy/done/wen/front=%b%b%b%b%b addr=%h data=%h, required 10000 0000 0000",
               wr_ready, swap_busy, swap_done, ram_w_en, front_bank, ram_w_addr, ram_w_data);
    end
    tick();
    rst_n = 1'b1;
    writes = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (ram_w_en !== 1'b0) writes++;
    end
    n_checks++;
    if (writes != 0 || wr_ready !== 1'b1) begin
      n_fail++; $display("FAIL no_writes_after_reset: writes=%0d rdy=%b, required 0 1", writes, wr_ready);
    end
  endtask
`else
  task automatic test_no_clear();
    int writes;
    swap_req = 1'b1;
    tick();
    swap_req = 1'b0;
    frame_end = 1'b1;
    tick();
    frame_end = 1'b0;
    n_checks++;
    if (front_bank !== 1'b0 || swap_done !== 1'b1 || wr_ready !== 1'b1 || swap_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL swap_no_clear: front=%b done=%b rdy=%b busy=%b, required 0 1 1 0",
               front_bank, swap_done, wr_ready, swap_busy);
    end
    writes = 0;
    for (int i = 0; i < 10; i++) begin
      if (ram_w_en !== 1'b0) writes++;
      tick();
    end
    n_checks++;
    if (writes != 0) begin
      n_fail++; $display("FAIL no_clear_writes: writes=%0d, required 0", writes);
    end
  endtask

  task automatic test_reset_mid();
    swap_req = 1'b1;
    tick();
    swap_req = 1'b0;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({wr_ready, swap_busy, swap_done, ram_w_en, front_bank} !== 5'b10000) begin
      n_fail++;
      $display("FAIL reset_mid_pending: rdy/busy/done/wen/front=%b%b%b%b%b, required 10000",
               wr_ready, swap_busy, swap_done, ram_w_en, front_bank);
    end
    tick();
    rst_n = 1'b1;
    tick();
    frame_end = 1'b1;
    tick();
    frame_end = 1'b0;
    n_checks++;
    if (front_bank !== 1'b0 || swap_done !== 1'b0 || ram_w_en !== 1'b0) begin
      n_fail++;
      $display("FAIL pending_abandoned: front=%b done=%b wen=%b, required 0 0 0", front_bank, swap_done, ram_w_en);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_write();
    test_swap();
    test_same_cycle();
`ifdef PIXEL_BANK_CLEAR_EN
    test_clear();
`else
    test_no_clear();
`endif
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
